// File: rtl/fix_stream_checker.sv
// Outbound FIX byte-stream checker: expected-byte queue compare with wildcards, host check,
// first-error capture and clean-message counter. FIX_CHK_CHECKSUM_EN adds tag-10 checksum/framing.
module fix_stream_checker #(
  parameter int unsigned EXP_DEPTH = 16,
  parameter int unsigned NUM_HOST  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                exp_valid_i,
  input  logic [7:0]          exp_data_i,
  input  logic                exp_wild_i,
  output logic                exp_ready_o,
  input  logic [NUM_HOST-1:0] exp_host_i,
  input  logic                dut_valid_i,
  input  logic [7:0]          dut_data_i,
  input  logic                dut_end_i,
  input  logic [NUM_HOST-1:0] dut_host_i,
  output logic                error_o,
  output logic [2:0]          err_code_o,
  output logic [7:0]          err_got_o,
  output logic [7:0]          err_exp_o,
  output logic [CNT_W-1:0]    msg_count_o
);

  localparam int unsigned AW = $clog2(EXP_DEPTH);
  localparam int unsigned EW = NUM_HOST + 9;

  localparam logic [2:0] ErrMismatch  = 3'd1;
  localparam logic [2:0] ErrUnderflow = 3'd2;
  localparam logic [2:0] ErrChecksum  = 3'd3;
  localparam logic [2:0] ErrFrame     = 3'd4;
  localparam logic [2:0] ErrHost      = 3'd5;

  // Host id travels with each entry; only the copy on a message's first byte is compared.
  logic [EW-1:0] mem_q [EXP_DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          ready_q, empty, push, pop, full_d;
  logic [EW-1:0] head;
  logic          first_q;

  assign empty  = (wptr_q == rptr_q);
  assign push   = exp_valid_i && ready_q;
  assign pop    = dut_valid_i && !empty;
  assign head   = mem_q[rptr_q[AW-1:0]];
  assign wptr_d = clear_i ? '0 : wptr_q + (AW+1)'(push);
  assign rptr_d = clear_i ? '0 : rptr_q + (AW+1)'(pop);
  assign full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push && !clear_i) mem_q[wptr_q[AW-1:0]] <= {exp_host_i, exp_wild_i, exp_data_i};
  end

  logic       frame_err, cks_err;
  logic [7:0] cks_exp;

`ifdef FIX_CHK_CHECKSUM_EN
  typedef enum logic [3:0] {StIdle, StBody, StT1, StT0, StTeq, StD0, StD1, StD2, StTrl} state_e;
  state_e     state_q, state_d;
  logic [7:0] sum_q, sum_d, sum_soh_q, sum_soh_d, sum_next;
  logic [9:0] val_q, val_d;
  logic       is_soh, is_digit, to_body;
  logic [3:0] digit;

  assign sum_next = sum_q + dut_data_i;
  assign is_soh   = (dut_data_i == 8'h01);
  assign is_digit = (dut_data_i >= 8'h30) && (dut_data_i <= 8'h39);
  assign digit    = dut_data_i[3:0];
  assign cks_exp  = sum_soh_q;

  // States are named for the byte they wait for; an SOH arms the search for "10=".
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    sum_soh_d = sum_soh_q;
    val_d     = val_q;
    frame_err = 1'b0;
    cks_err   = 1'b0;
    to_body   = 1'b0;
    if (dut_valid_i) begin
      sum_d = sum_next;
      unique case (state_q)
        StIdle, StBody: to_body = 1'b1;
        StT1:  if (dut_data_i == 8'h31) state_d = StT0;  else to_body = 1'b1;
        StT0:  if (dut_data_i == 8'h30) state_d = StTeq; else to_body = 1'b1;
        StTeq: if (dut_data_i == 8'h3D) state_d = StD0;  else to_body = 1'b1;
        StD0, StD1, StD2: begin
          if (!is_digit) begin
            frame_err = 1'b1;
            state_d   = StBody;
          end else begin
            unique case (state_q)
              StD0:    begin val_d = 10'(digit) * 10'd100;         state_d = StD1; end
              StD1:    begin val_d = val_q + 10'(digit) * 10'd10;  state_d = StD2; end
              default: begin val_d = val_q + 10'(digit);           state_d = StTrl; end
            endcase
          end
        end
        StTrl: begin
          if (!(is_soh && dut_end_i)) frame_err = 1'b1;
          else if (val_q != {2'b00, sum_soh_q}) cks_err = 1'b1;
          state_d = StBody;
        end
        default: state_d = StIdle;
      endcase
      if (to_body) begin
        state_d = is_soh ? StT1 : StBody;
        if (is_soh) sum_soh_d = sum_next;
      end
      if (dut_end_i) begin
        if (state_q != StTrl) frame_err = 1'b1;
        state_d = StIdle;
        sum_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sum_q     <= '0;
      sum_soh_q <= '0;
      val_q     <= '0;
    end else if (clear_i) begin
      state_q   <= StIdle;
      sum_q     <= '0;
      sum_soh_q <= '0;
      val_q     <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      sum_soh_q <= sum_soh_d;
      val_q     <= val_d;
    end
  end
`else
  assign frame_err = 1'b0;
  assign cks_err   = 1'b0;
  assign cks_exp   = 8'h00;
`endif

  logic       err_now;
  logic [2:0] code_now;
  logic [7:0] exp_now;

  always_comb begin
    err_now  = 1'b0;
    code_now = 3'd0;
    exp_now  = empty ? 8'h00 : head[7:0];
    if (dut_valid_i) begin
      err_now = 1'b1;
      if (empty)                                      code_now = ErrUnderflow;
      else if (!(head[8] || head[7:0] == dut_data_i)) code_now = ErrMismatch;
      else if (first_q && head[EW-1:9] != dut_host_i) code_now = ErrHost;
      else if (cks_err) begin
        code_now = ErrChecksum;
        exp_now  = cks_exp;
      end
      else if (frame_err)                             code_now = ErrFrame;
      else                                            err_now  = 1'b0;
    end
  end

  logic             error_q;
  logic [2:0]       code_q;
  logic [7:0]       got_q, exp_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b1;
      first_q <= 1'b1;
      error_q <= 1'b0;
      code_q  <= '0;
      got_q   <= '0;
      exp_q   <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= !full_d;
      if (clear_i) begin
        first_q <= 1'b1;
        error_q <= 1'b0;
        code_q  <= '0;
        got_q   <= '0;
        exp_q   <= '0;
        count_q <= '0;
      end else begin
        if (dut_valid_i) first_q <= dut_end_i;
        if (err_now && !error_q) begin
          error_q <= 1'b1;
          code_q  <= code_now;
          got_q   <= dut_data_i;
          exp_q   <= exp_now;
        end
        if (dut_valid_i && dut_end_i && !err_now && !error_q && count_q != {CNT_W{1'b1}})
          count_q <= count_q + 1'b1;
      end
    end
  end

  assign exp_ready_o = ready_q;
  assign error_o     = error_q;
  assign err_code_o  = code_q;
  assign err_got_o   = got_q;
  assign err_exp_o   = exp_q;
  assign msg_count_o = count_q;

endmodule

// File: tb/tb_fix_stream_checker.sv
// Directed bench for fix_stream_checker; checksum expectations follow FIX_CHK_CHECKSUM_EN.
module tb_fix_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        exp_valid_i = 1'b0;
  logic [7:0]  exp_data_i = '0;
  logic        exp_wild_i = 1'b0;
  logic        exp_ready_o;
  logic [1:0]  exp_host_i = 2'b01;
  logic        dut_valid_i = 1'b0;
  logic [7:0]  dut_data_i = '0;
  logic        dut_end_i = 1'b0;
  logic [1:0]  dut_host_i = 2'b01;
  logic        error_o;
  logic [2:0]  err_code_o;
  logic [7:0]  err_got_o;
  logic [7:0]  err_exp_o;
  logic [15:0] msg_count_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] good_msg [9];
  logic [7:0] bad_msg  [9];

  fix_stream_checker #(.EXP_DEPTH(16), .NUM_HOST(2), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_i),
    .exp_valid_i(exp_valid_i),
    .exp_data_i (exp_data_i),
    .exp_wild_i (exp_wild_i),
    .exp_ready_o(exp_ready_o),
    .exp_host_i (exp_host_i),
    .dut_valid_i(dut_valid_i),
    .dut_data_i (dut_data_i),
    .dut_end_i  (dut_end_i),
    .dut_host_i (dut_host_i),
    .error_o    (error_o),
    .err_code_o (err_code_o),
    .err_got_o  (err_got_o),
    .err_exp_o  (err_exp_o),
    .msg_count_o(msg_count_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; consecutive calls give back-to-back beats.
  task automatic push(input logic [7:0] d, input logic w);
    @(negedge clk);
    exp_valid_i = 1'b1;
    exp_data_i  = d;
    exp_wild_i  = w;
  endtask

  task automatic beat(input logic [7:0] d, input logic e);
    @(negedge clk);
    exp_valid_i = 1'b0;
    dut_valid_i = 1'b1;
    dut_data_i  = d;
    dut_end_i   = e;
  endtask

  task automatic idle();
    @(negedge clk);
    exp_valid_i = 1'b0;
    dut_valid_i = 1'b0;
    dut_end_i   = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    exp_valid_i = 1'b0;
    dut_valid_i = 1'b0;
    clear_i     = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  task automatic push_good(input logic w);
    for (int i = 0; i < 9; i++) push(good_msg[i], w);
    idle();
  endtask

  task automatic send_good();
    for (int i = 0; i < 9; i++) beat(good_msg[i], i == 8);
    idle();
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_ready"}, 32'(exp_ready_o), 32'd1);
    check_eq({pfx, "_error"}, 32'(error_o), 32'd0);
    check_eq({pfx, "_code"}, 32'(err_code_o), 32'd0);
    check_eq({pfx, "_got"}, 32'(err_got_o), 32'd0);
    check_eq({pfx, "_exp"}, 32'(err_exp_o), 32'd0);
    check_eq({pfx, "_count"}, 32'(msg_count_o), 32'd0);
  endtask

  initial begin
    good_msg = '{8'h41, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h36, 8'h36, 8'h01};
    bad_msg  = '{8'h41, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h36, 8'h37, 8'h01};
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Two clean messages
    push_good(1'b0);
    send_good();
    check_eq("clean_error", 32'(error_o), 32'd0);
    check_eq("clean_count1", 32'(msg_count_o), 32'd1);
    push_good(1'b0);
    send_good();
    check_eq("clean_count2", 32'(msg_count_o), 32'd2);

    // First-byte mismatch
    do_clear();
    check_eq("clear_count", 32'(msg_count_o), 32'd0);
    push_good(1'b0);
    beat(8'h42, 1'b0);
    for (int i = 1; i < 9; i++) beat(good_msg[i], i == 8);
    idle();
    check_eq("mm_error", 32'(error_o), 32'd1);
    check_eq("mm_code", 32'(err_code_o), 32'd1);
    check_eq("mm_got", 32'(err_got_o), 32'h42);
    check_eq("mm_exp", 32'(err_exp_o), 32'h41);
    check_eq("mm_count", 32'(msg_count_o), 32'd0);

    // Wildcard, then underflow
    do_clear();
    push(8'h41, 1'b0);
    push(8'h00, 1'b1);
    idle();
    beat(8'h41, 1'b0);
    beat(8'h55, 1'b0);
    idle();
    check_eq("wild_error", 32'(error_o), 32'd0);
    beat(8'h77, 1'b0);
    idle();
    check_eq("uf_code", 32'(err_code_o), 32'd2);
    check_eq("uf_got", 32'(err_got_o), 32'h77);

    // Wrong checksum digit under an all-wild queue
    do_clear();
    push_good(1'b1);
    for (int i = 0; i < 9; i++) beat(bad_msg[i], i == 8);
    idle();
`ifdef FIX_CHK_CHECKSUM_EN
    check_eq("cks_code", 32'(err_code_o), 32'd3);
    check_eq("cks_got", 32'(err_got_o), 32'h01);
    check_eq("cks_exp", 32'(err_exp_o), 32'h42);
    check_eq("cks_count", 32'(msg_count_o), 32'd0);

    // End outside the trailer
    do_clear();
    push(8'h41, 1'b0);
    push(8'h01, 1'b0);
    idle();
    beat(8'h41, 1'b0);
    beat(8'h01, 1'b1);
    idle();
    check_eq("frame_code", 32'(err_code_o), 32'd4);
    check_eq("frame_got", 32'(err_got_o), 32'h01);
`else
    check_eq("nocks_error", 32'(error_o), 32'd0);
    check_eq("nocks_count", 32'(msg_count_o), 32'd1);
`endif

    // Host id mismatch on first beat
    do_clear();
    exp_host_i = 2'b01;
    push_good(1'b0);
    dut_host_i = 2'b10;
    send_good();
    dut_host_i = 2'b01;
    check_eq("host_code", 32'(err_code_o), 32'd5);
    check_eq("host_got", 32'(err_got_o), 32'h41);
    check_eq("host_count", 32'(msg_count_o), 32'd0);

    // Fill the queue; the 17th push must be dropped
    do_clear();
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    idle();
    check_eq("full_ready", 32'(exp_ready_o), 32'd0);
    push(8'hEE, 1'b0);
    idle();
    check_eq("full_ready2", 32'(exp_ready_o), 32'd0);
    for (int i = 0; i < 16; i++) beat(8'(i), 1'b0);
    idle();
    check_eq("drain_error", 32'(error_o), 32'd0);
    check_eq("drain_ready", 32'(exp_ready_o), 32'd1);
    beat(8'h99, 1'b0);
    idle();
    check_eq("drop_code", 32'(err_code_o), 32'd2);
    check_eq("drop_got", 32'(err_got_o), 32'h99);

    // Asynchronous reset mid-message
    push(8'h41, 1'b0);
    push(8'h01, 1'b0);
    idle();
    beat(8'h41, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    push_good(1'b0);
    send_good();
    check_eq("post_rst_count", 32'(msg_count_o), 32'd1);
    check_eq("post_rst_error", 32'(error_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
